led_counter_ctrl: RTL and testbench

//  Button-driven sequencer for the 4-bit LED counter datapath on the Zybo board.

---
 rtl/led_counter_ctrl_if.sv | 22 ++
 rtl/led_counter_ctrl.sv | 151 +++++++++++++++
 tb/tb_led_counter_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_counter_ctrl_if.sv
// rtl/led_counter_ctrl_if.sv - board-side bundle: raw push buttons in, LED count and status out
interface led_counter_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             btn_start;
  logic             btn_stop;
  logic             btn_dir;
  logic             btn_clr;
  logic [CNT_W-1:0] leds;
  logic             running;
  logic             dir_up;

  modport master (
    output btn_start, btn_stop, btn_dir, btn_clr,
    input  leds, running, dir_up
  );

  modport slave (
    input  btn_start, btn_stop, btn_dir, btn_clr,
    output leds, running, dir_up
  );
endinterface

// File: rtl/led_counter_ctrl.sv
// rtl/led_counter_ctrl.sv - button-driven start/stop/clear sequencer for a prescaled up/down LED count
// Optional per-button debouncer enabled by defining LED_COUNTER_CTRL_DEBOUNCE_EN.
module led_counter_ctrl #(
  parameter int PRESCALE        = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int CNT_W           = 4
) (
  input logic              clk,
  input logic              rst_n,
  led_counter_ctrl_if.slave bus
);

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("led_counter_ctrl: PRESCALE must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("led_counter_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Button lanes: bit 0 start, 1 stop, 2 dir, 3 clr.
  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2;
  logic [3:0] level, level_d;
  logic [3:0] press;

  assign btn_raw = {bus.btn_clr, bus.btn_dir, bus.btn_stop, bus.btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef LED_COUNTER_CTRL_DEBOUNCE_EN
  localparam int            DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt [4];
  logic [3:0]    db_level;

  // A lane's accepted level flips only after the synced input has disagreed
  // with it on DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i]   <= '0;
          db_level[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  // Registered rising-edge detect: one press pulse per release/re-press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= '0;
      press   <= '0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

  logic start_p, stop_p, dir_p, clr_p;
  assign start_p = press[0];
  assign stop_p  = press[1];
  assign dir_p   = press[2];
  assign clr_p   = press[3];

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      leds_q  <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      leds_q  <= leds_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    leds_d  = leds_q;
    dir_d   = dir_q ^ dir_p;
    tick    = (state_q == RUN) && (presc_q == PRESC_MAX);

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (start_p) state_d = RUN;
      end
      RUN: begin
        // The step uses dir_q, so a coincident dir press affects the next tick.
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) leds_d = dir_q ? leds_q + 1'b1 : leds_q - 1'b1;
        if (stop_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (start_p && !stop_p) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (clr_p) begin
      state_d = IDLE;
      presc_d = '0;
      leds_d  = '0;
    end
  end

  assign bus.leds    = leds_q;
  assign bus.running = (state_q == RUN);
  assign bus.dir_up  = dir_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb/tb_led_counter_ctrl.sv - directed + randomized bench for led_counter_ctrl (LED_COUNTER_CTRL_DEBOUNCE_EN optional)
module tb_led_counter_ctrl;

  localparam int PRESCALE = 4;
  localparam int D        = 3;
  localparam int CNT_W    = 4;
`ifdef LED_COUNTER_CTRL_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
  localparam int LAT   = 3 + D;
  localparam int DL    = 4;
`else
  localparam bit DB_ON = 1'b0;
  localparam int LAT   = 3;
  localparam int DL    = 3;
`endif
  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_STOP  = 4'b0010;
  localparam logic [3:0] B_DIR   = 4'b0100;
  localparam logic [3:0] B_CLR   = 4'b1000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn   = '0;

  led_counter_ctrl_if #(.CNT_W(CNT_W)) bif ();
  assign bif.btn_start = btn[0];
  assign bif.btn_stop  = btn[1];
  assign bif.btn_dir   = btn[2];
  assign bif.btn_clr   = btn[3];

  led_counter_ctrl #(
    .PRESCALE       (PRESCALE),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: state, count, prescaler phase, direction, plus the
  // press-detection view of each button (conditioned level + fixed latency line).
  int       m_st, m_count, m_presc;
  bit       m_dir;
  bit [3:0] m_cond;
  bit [3:0] m_hist [D];
  bit [3:0] m_pipe [DL];

  task automatic model_reset();
    m_st = S_IDLE; m_count = 0; m_presc = 0; m_dir = 1'b1; m_cond = '0;
    for (int i = 0; i < D; i++) m_hist[i] = '0;
    for (int i = 0; i < DL; i++) m_pipe[i] = '0;
  endtask

  task automatic model_edge();
    bit [3:0] f, ncond;
    bit       tick, all_diff;
    if (!rst_n) begin
      model_reset();
    end else begin
      f = m_pipe[DL-1];
      for (int i = DL - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = btn;
      if (DB_ON) begin
        ncond = m_cond;
        for (int b = 0; b < 4; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (m_hist[j][b] == m_cond[b]) all_diff = 1'b0;
          if (all_diff) ncond[b] = ~m_cond[b];
        end
      end else begin
        ncond = btn;
      end
      m_pipe[0] = ncond & ~m_cond;
      m_cond    = ncond;

      tick = (m_st == S_RUN) && (m_presc == PRESCALE - 1);
      if (m_st == S_RUN) begin
        m_presc = (m_presc + 1) % PRESCALE;
        if (tick) m_count = m_dir ? (m_count + 1) % 16 : (m_count + 15) % 16;
      end else if (m_st == S_IDLE) begin
        m_presc = 0;
      end
      if (f[2]) m_dir = ~m_dir;
      if (f[3]) begin
        m_st = S_IDLE; m_count = 0; m_presc = 0;
      end else if (m_st == S_IDLE && f[0]) begin
        m_st = S_RUN;
      end else if (m_st == S_RUN && f[1]) begin
        m_st = S_PAUSE;
      end else if (m_st == S_PAUSE && f[0] && !f[1]) begin
        m_st = S_RUN;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [5:0] o, e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    o = {bif.leds, bif.running, bif.dir_up};
    e = {m_count[3:0], (m_st == S_RUN), m_dir};
    chk("cycle", 32'(o), 32'(e));
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    btn = btn | m;
    repeat (hold) cyc();
    btn = btn & ~m;
    repeat (gap) cyc();
  endtask

  // Phase = count*PRESCALE + prescaler, observed just after an edge while running.
  task automatic wait_phase(input int p, input string tag);
    int n = 0;
    while (n < 400 && !(m_st == S_RUN && (m_count * PRESCALE + m_presc) == p)) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < 400), 1);
  endtask

  initial begin
    int          n, v;
    int unsigned r;
    logic [3:0]  m;

    model_reset();
    repeat (3) cyc();
    chk("rst_leds", 32'(bif.leds), 0);
    chk("rst_running", 32'(bif.running), 0);
    chk("rst_dir", 32'(bif.dir_up), 1);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Count and wrap from IDLE
    press(B_START, LAT + 2, D + 2);
    chk("start_running", 32'(bif.running), 1);
    n = 0; while (n < 100 && m_count != 15) begin cyc(); n++; end
    chk("reach15", 32'(bif.leds), 15);
    n = 0; while (n < 10 && m_count != 0) begin cyc(); n++; end
    chk("wrap0", 32'(bif.leds), 0);
    chk("wrap_running", 32'(bif.running), 1);

    // Pause at leds=5 / prescaler=2, then resume
    wait_phase(21 - LAT, "ph_stop");
    press(B_STOP, LAT + 2, 6);
    chk("paused_leds", 32'(bif.leds), 5);
    chk("paused_running", 32'(bif.running), 0);
    btn = btn | B_START;
    n = 0; while (n < 20 && m_st != S_RUN) begin cyc(); n++; end
    chk("resume_reached", 32'(n < 20), 1);
    cyc();
    chk("resume_e1", 32'(bif.leds), 5);
    cyc();
    chk("resume_e2", 32'(bif.leds), 6);
    btn = btn & ~B_START;
    repeat (D + 2) cyc();

    // Direction toggle in RUN at leds=0
    wait_phase(64 + 1 - LAT, "ph_dir");
    press(B_DIR, LAT + 2, 0);
    chk("dir_toggled", 32'(bif.dir_up), 0);
    v = m_count;
    n = 0; while (n < 10 && m_count == v) begin cyc(); n++; end
    chk("dir_step1", 32'(bif.leds), 32'((v + 15) % 16));
    n = 0; while (n < 10 && m_count == (v + 15) % 16) begin cyc(); n++; end
    chk("dir_step2", 32'(bif.leds), 32'((v + 14) % 16));
    repeat (D + 2) cyc();

    // Dir press landing on a tick: that step still counts down
    n = 0;
    while (n < 20 && !(m_st == S_RUN && m_presc == (3 - LAT + 8) % PRESCALE)) begin cyc(); n++; end
    chk("coinc_reached", 32'(n < 20), 1);
    v = m_count;
    btn = btn | B_DIR;
    repeat (LAT + 1) cyc();
    chk("coinc_step", 32'(bif.leds), 32'((v + 15) % 16));
    chk("coinc_dir", 32'(bif.dir_up), 1);
    btn = btn & ~B_DIR;
    n = 0; while (n < 10 && m_count == (v + 15) % 16) begin cyc(); n++; end
    chk("coinc_next", 32'(bif.leds), 32'(v));
    press(B_DIR, LAT + 2, D + 2);
    chk("dir_down_again", 32'(bif.dir_up), 0);

    // Asynchronous reset mid-run at leds=9
    wait_phase(36, "ph_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_leds", 32'(bif.leds), 0);
    chk("async_running", 32'(bif.running), 0);
    chk("async_dir", 32'(bif.dir_up), 1);
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Priority cases
    press(B_START, LAT + 2, D + 2);
    wait_phase(28 - LAT, "ph_p7");
    press(B_STOP, LAT + 2, D + 2);
    chk("p7_leds", 32'(bif.leds), 7);
    chk("p7_running", 32'(bif.running), 0);
    press(B_CLR | B_START, LAT + 2, D + 2);
    chk("clr_leds", 32'(bif.leds), 0);
    chk("clr_running", 32'(bif.running), 0);
    press(B_START, LAT + 2, 5);
    chk("restart", 32'(bif.running), 1);
    press(B_STOP | B_START, LAT + 2, D + 2);
    chk("ss_run_pause", 32'(bif.running), 0);
    press(B_CLR, LAT + 2, D + 2);
    press(B_STOP | B_START, LAT + 2, D + 2);
    chk("ss_idle_run", 32'(bif.running), 1);
    press(B_CLR, LAT + 2, D + 2);

    // Short glitch on start, then a long held press
    btn = btn | B_START;
    repeat (2) cyc();
    btn = '0;
    repeat (20) cyc();
    chk("glitch", 32'(bif.running), DB_ON ? 0 : 1);
    press(B_CLR, LAT + 2, D + 2);
    press(B_START, 100, D + 2);
    chk("long_press", 32'(bif.running), 1);

    // Randomized button traffic against the model
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: m = B_START;
        4, 5:       m = B_STOP;
        6, 7:       m = B_DIR;
        8:          m = B_CLR;
        default:    m = B_START | B_STOP;
      endcase
      if ($urandom_range(0, 4) == 0) m = m | 4'(1 << $urandom_range(0, 3));
      press(m, int'($urandom_range(1, D + 8)), int'($urandom_range(1, 30)));
    end
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
